pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, meaning cycles held in DRAIN before a syscall issues (range 1..7).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports id_rs_i, id_rt_i  input  5 each  source registers of the instruction in ID.
REQ-005 SHALL have ports id_usesRs_i, id_usesRt_i  input  1 each  ID instruction reads rs / rt.
REQ-006 SHALL have port id_syscall_i  input  1  ID instruction is a syscall.
REQ-007 SHALL have ports ex_writeReg_i (5), ex_regWrite_i (1), ex_memRead_i (1)  input  destination, write enable and load flag of the instruction in EX.
REQ-008 SHALL have ports mem_writeReg_i (5), mem_regWrite_i (1)  input  destination and write enable of the instruction in MEM.
REQ-009 SHALL have port redirect_i  input  1  taken branch/jump resolved in EX.
REQ-010 SHALL have port syscallDone_i  input  1  syscall handler completion pulse.
REQ-011 SHALL have port stall_o  output  1  hold PC and IF/ID register.
REQ-012 SHALL have port loadFlush_o  output  1  bubble into the ID/EX register.
REQ-013 SHALL have ports bypassingControl1_o, bypassingControl2_o  output  1 each  replace rs / rt read data with a bypass result.
REQ-014 SHALL have ports bypassSrc1_o, bypassSrc2_o  output  1 each  bypass source: 0 = EX result, 1 = MEM result.
REQ-015 SHALL have port syscallReq_o  output  1  syscall issue pulse to handler.
REQ-016 SHALL have port stallCount_o  output  16  saturating count of load-use stall cycles.

Function
REQ-017 SHALL define hitEX(r) = ex_regWrite_i & (ex_writeReg_i == r) & (r != 0), and hitMEM(r) likewise on the MEM inputs.
REQ-018 SHALL assert loaduse when ex_memRead_i & ((id_usesRs_i & hitEX(id_rs_i)) | (id_usesRt_i & hitEX(id_rt_i))).
REQ-019 SHALL drive bypassingControl1_o = id_usesRs_i & (hitEX(id_rs_i) | hitMEM(id_rs_i)) & !loaduse, with bypassSrc1_o = !hitEX(id_rs_i); rs/rt treated identically (EX has priority over MEM).
REQ-020 SHALL never bypass register 0, and SHALL produce all outputs combinationally from the current inputs and registered state (zero latency).
REQ-021 SHALL implement the FSM states RUN, DRAIN, ISSUE, WAIT with a 3-bit drain counter.
REQ-022 In RUN: loaduse -> stall_o=1, loadFlush_o=1; otherwise id_syscall_i -> stall_o=1, loadFlush_o=1, counter loaded with DRAIN_CYCLES-1, next DRAIN.
REQ-023 In DRAIN: stall_o=1, loadFlush_o=1, counter decrements; at counter==0 the next state is ISSUE.
REQ-024 In ISSUE: stall_o=0, loadFlush_o=0, syscallReq_o=1 for exactly one cycle; next WAIT.
REQ-025 In WAIT: stall_o=1, loadFlush_o=1 until syscallDone_i; on syscallDone_i, outputs as RUN that same cycle, next RUN.
REQ-026 redirect_i SHALL force loadFlush_o=1 and stall_o=0 in RUN and DRAIN, and in DRAIN SHALL abort to RUN (squashed syscall); redirect_i in ISSUE/WAIT SHALL be ignored.
REQ-027 Loaduse and redirect_i in the same cycle -> redirect wins; no stall is counted.
REQ-028 stallCount_o SHALL increment on every cycle where a load-use stall is applied, saturating at 16'hFFFF.
REQ-029 syscallReq_o SHALL be 0 in every state except ISSUE.

Reset
REQ-030 While rst_i is high: state=RUN, counter=0, stallCount_o=0, loadFlush_o=1, all other outputs 0.
REQ-031 Reset asserted mid-DRAIN/WAIT SHALL abandon the syscall immediately; after release, behaviour SHALL be identical to power-on.

Verification
REQ-032 EX load to r5, ID uses rs=5 -> stall_o=1, loadFlush_o=1 one cycle, stallCount_o 0->1; next cycle (load in MEM) bypassingControl1_o=1, bypassSrc1_o=1.
REQ-033 EX writes r3 (no load), MEM writes r3, ID rt=3 -> bypassingControl2_o=1, bypassSrc2_o=0, no stall.
REQ-034 EX load to r0, ID rs=0 -> no stall, no bypass.
REQ-035 Syscall in ID, DRAIN_CYCLES=3 -> 1 RUN + 2 DRAIN cycles stalled, ISSUE pulse, WAIT until syscallDone_i, then RUN.
REQ-036 redirect_i during second DRAIN cycle -> loadFlush_o=1, stall_o=0, next RUN, no syscallReq_o.
REQ-037 Force stallCount_o to 16'hFFFE, apply 3 load-use stalls -> holds 16'hFFFF; rst_i pulse mid-WAIT -> RUN, stallCount_o=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: load-use stall, EX/MEM bypass select,
// branch flush and a drain/issue/wait sequencer that serialises syscalls.
module pipeline_hazard_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [4:0]  id_rs_i,
  input  logic [4:0]  id_rt_i,
  input  logic        id_usesRs_i,
  input  logic        id_usesRt_i,
  input  logic        id_syscall_i,
  input  logic [4:0]  ex_writeReg_i,
  input  logic        ex_regWrite_i,
  input  logic        ex_memRead_i,
  input  logic [4:0]  mem_writeReg_i,
  input  logic        mem_regWrite_i,
  input  logic        redirect_i,
  input  logic        syscallDone_i,
  output logic        stall_o,
  output logic        loadFlush_o,
  output logic        bypassingControl1_o,
  output logic        bypassingControl2_o,
  output logic        bypassSrc1_o,
  output logic        bypassSrc2_o,
  output logic        syscallReq_o,
  output logic [15:0] stallCount_o
);

  // state | meaning
  // RUN   | normal issue; load-use stalls and syscall detection
  // DRAIN | syscall held in ID while older instructions retire
  // ISSUE | one-cycle request pulse to the syscall handler
  // WAIT  | pipeline frozen until the handler reports completion
  typedef enum logic [1:0] {RUN, DRAIN, ISSUE, WAIT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
  logic loaduse, count_stall;

  assign hit_ex_rs  = ex_regWrite_i  && (ex_writeReg_i  == id_rs_i) && (id_rs_i != 5'd0);
  assign hit_ex_rt  = ex_regWrite_i  && (ex_writeReg_i  == id_rt_i) && (id_rt_i != 5'd0);
  assign hit_mem_rs = mem_regWrite_i && (mem_writeReg_i == id_rs_i) && (id_rs_i != 5'd0);
  assign hit_mem_rt = mem_regWrite_i && (mem_writeReg_i == id_rt_i) && (id_rt_i != 5'd0);

  assign loaduse = ex_memRead_i && ((id_usesRs_i && hit_ex_rs) || (id_usesRt_i && hit_ex_rt));

  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    stall_count_d       = stall_count_q;
    count_stall         = 1'b0;
    stall_o             = 1'b0;
    loadFlush_o         = 1'b0;
    syscallReq_o        = 1'b0;
    bypassingControl1_o = id_usesRs_i && (hit_ex_rs || hit_mem_rs) && !loaduse;
    bypassingControl2_o = id_usesRt_i && (hit_ex_rt || hit_mem_rt) && !loaduse;
    bypassSrc1_o        = !hit_ex_rs;
    bypassSrc2_o        = !hit_ex_rt;

    case (state_q)
      RUN: begin
        if (redirect_i) begin
          loadFlush_o = 1'b1;
        end else if (loaduse) begin
          stall_o     = 1'b1;
          loadFlush_o = 1'b1;
          count_stall = 1'b1;
        end else if (id_syscall_i) begin
          stall_o     = 1'b1;
          loadFlush_o = 1'b1;
          cnt_d       = 3'(DRAIN_CYCLES - 1);
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (redirect_i) begin
          loadFlush_o = 1'b1;
          cnt_d       = 3'd0;
          state_d     = RUN;
        end else begin
          stall_o     = 1'b1;
          loadFlush_o = 1'b1;
          cnt_d       = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
          // leave once the decremented count hits zero; never stay past an empty count
          if (cnt_q <= 3'd1) state_d = ISSUE;
        end
      end
      ISSUE: begin
        syscallReq_o = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        if (syscallDone_i) begin
          state_d = RUN;
          if (loaduse) begin
            stall_o     = 1'b1;
            loadFlush_o = 1'b1;
            count_stall = 1'b1;
          end
        end else begin
          stall_o     = 1'b1;
          loadFlush_o = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (count_stall && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;

    // outputs are combinational, so reset must override them directly
    if (rst_i) begin
      stall_o             = 1'b0;
      loadFlush_o         = 1'b1;
      syscallReq_o        = 1'b0;
      bypassingControl1_o = 1'b0;
      bypassingControl2_o = 1'b0;
      bypassSrc1_o        = 1'b0;
      bypassSrc2_o        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stallCount_o = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboarded directed bench for pipeline_hazard_ctrl: driver pushes expected
// outputs per cycle, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       sys;
    logic [4:0] exw;
    logic       exrw;
    logic       exmr;
    logic [4:0] memw;
    logic       memrw;
    logic       redir;
    logic       done;
  } in_t;

  typedef struct {
    string       tag;
    logic        stall;
    logic        flush;
    logic        b1;
    logic        b2;
    logic        s1;
    logic        s2;
    logic        req;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [4:0]  id_rs_i = '0, id_rt_i = '0;
  logic        id_usesRs_i = 1'b0, id_usesRt_i = 1'b0, id_syscall_i = 1'b0;
  logic [4:0]  ex_writeReg_i = '0;
  logic        ex_regWrite_i = 1'b0, ex_memRead_i = 1'b0;
  logic [4:0]  mem_writeReg_i = '0;
  logic        mem_regWrite_i = 1'b0, redirect_i = 1'b0, syscallDone_i = 1'b0;
  logic        stall_o, loadFlush_o, bypassingControl1_o, bypassingControl2_o;
  logic        bypassSrc1_o, bypassSrc2_o, syscallReq_o;
  logic [15:0] stallCount_o;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;

  pipeline_hazard_ctrl #(.DRAIN_CYCLES(3)) dut (
    .clk(clk), .rst_i(rst_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_usesRs_i(id_usesRs_i), .id_usesRt_i(id_usesRt_i),
    .id_syscall_i(id_syscall_i),
    .ex_writeReg_i(ex_writeReg_i), .ex_regWrite_i(ex_regWrite_i), .ex_memRead_i(ex_memRead_i),
    .mem_writeReg_i(mem_writeReg_i), .mem_regWrite_i(mem_regWrite_i),
    .redirect_i(redirect_i), .syscallDone_i(syscallDone_i),
    .stall_o(stall_o), .loadFlush_o(loadFlush_o),
    .bypassingControl1_o(bypassingControl1_o), .bypassingControl2_o(bypassingControl2_o),
    .bypassSrc1_o(bypassSrc1_o), .bypassSrc2_o(bypassSrc2_o),
    .syscallReq_o(syscallReq_o), .stallCount_o(stallCount_o)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input string tag, input logic st, input logic fl,
                              input logic b1, input logic b2, input logic s1,
                              input logic s2, input logic rq, input logic [15:0] c);
    exp_t e;
    e.tag = tag; e.stall = st; e.flush = fl; e.b1 = b1; e.b2 = b2;
    e.s1 = s1; e.s2 = s2; e.req = rq; e.cnt = c;
    return e;
  endfunction

  function automatic in_t idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  // EX holds a load to r5 and ID reads rs=5
  function automatic in_t ld5();
    in_t v;
    v = '0;
    v.exw = 5'd5; v.exrw = 1'b1; v.exmr = 1'b1; v.rs = 5'd5; v.urs = 1'b1;
    return v;
  endfunction

  task automatic apply(input in_t v, input exp_t e);
    @(posedge clk);
    #1;
    rst_i = v.rst; id_rs_i = v.rs; id_rt_i = v.rt;
    id_usesRs_i = v.urs; id_usesRt_i = v.urt; id_syscall_i = v.sys;
    ex_writeReg_i = v.exw; ex_regWrite_i = v.exrw; ex_memRead_i = v.exmr;
    mem_writeReg_i = v.memw; mem_regWrite_i = v.memrw;
    redirect_i = v.redir; syscallDone_i = v.done;
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (expq.size() != 0) begin
      exp_t e;
      e = expq.pop_front();
      checks++;
      if ({stall_o, loadFlush_o, bypassingControl1_o, bypassingControl2_o,
           bypassSrc1_o, bypassSrc2_o, syscallReq_o, stallCount_o} !==
          {e.stall, e.flush, e.b1, e.b2, e.s1, e.s2, e.req, e.cnt})
        $display("FAIL %s: got stall=%b flush=%b byp=%b%b src=%b%b req=%b cnt=%h, want stall=%b flush=%b byp=%b%b src=%b%b req=%b cnt=%h",
                 e.tag, stall_o, loadFlush_o, bypassingControl1_o, bypassingControl2_o,
                 bypassSrc1_o, bypassSrc2_o, syscallReq_o, stallCount_o,
                 e.stall, e.flush, e.b1, e.b2, e.s1, e.s2, e.req, e.cnt);
      else
        passed++;
    end
  end

  initial begin
    in_t v;
    logic [15:0] cur;

    // reset
    v = idle(); v.rst = 1'b1;
    apply(v, mk("rst_idle", 0, 1, 0, 0, 0, 0, 0, 16'd0));
    v = ld5(); v.rst = 1'b1;
    apply(v, mk("rst_loaduse", 0, 1, 0, 0, 0, 0, 0, 16'd0));
    apply(idle(), mk("run_idle", 0, 0, 0, 0, 1, 1, 0, 16'd0));

    // load-use then MEM bypass
    apply(ld5(), mk("loaduse_r5", 1, 1, 0, 0, 0, 1, 0, 16'd0));
    v = idle(); v.memw = 5'd5; v.memrw = 1'b1; v.rs = 5'd5; v.urs = 1'b1;
    apply(v, mk("mem_bypass_rs", 0, 0, 1, 0, 1, 1, 0, 16'd1));

    // EX beats MEM on rt; MEM-only on rt
    v = idle(); v.exw = 5'd3; v.exrw = 1'b1; v.memw = 5'd3; v.memrw = 1'b1; v.rt = 5'd3; v.urt = 1'b1;
    apply(v, mk("ex_prio_rt", 0, 0, 0, 1, 1, 0, 0, 16'd1));
    v = idle(); v.memw = 5'd7; v.memrw = 1'b1; v.rt = 5'd7; v.urt = 1'b1;
    apply(v, mk("mem_bypass_rt", 0, 0, 0, 1, 1, 1, 0, 16'd1));

    // register 0 and unused operand
    v = idle(); v.exw = 5'd0; v.exrw = 1'b1; v.exmr = 1'b1; v.urs = 1'b1;
    apply(v, mk("ex_load_r0", 0, 0, 0, 0, 1, 1, 0, 16'd1));
    v = idle(); v.memrw = 1'b1; v.urs = 1'b1;
    apply(v, mk("mem_r0", 0, 0, 0, 0, 1, 1, 0, 16'd1));
    v = ld5(); v.urs = 1'b0;
    apply(v, mk("rs_unused", 0, 0, 0, 0, 0, 1, 0, 16'd1));

    // load-use on rt suppresses an otherwise valid rs bypass
    v = idle(); v.exw = 5'd9; v.exrw = 1'b1; v.exmr = 1'b1; v.rt = 5'd9; v.urt = 1'b1;
    v.rs = 5'd4; v.urs = 1'b1; v.memw = 5'd4; v.memrw = 1'b1;
    apply(v, mk("loaduse_rt", 1, 1, 0, 0, 1, 0, 0, 16'd1));

    // redirect beats load-use, not counted
    v = idle(); v.exw = 5'd9; v.exrw = 1'b1; v.exmr = 1'b1; v.rt = 5'd9; v.urt = 1'b1; v.redir = 1'b1;
    apply(v, mk("redir_vs_loaduse", 0, 1, 0, 0, 1, 0, 0, 16'd2));
    apply(idle(), mk("after_redir", 0, 0, 0, 0, 1, 1, 0, 16'd2));

    // full syscall sequence
    v = idle(); v.sys = 1'b1;
    apply(v, mk("sys_run", 1, 1, 0, 0, 1, 1, 0, 16'd2));
    apply(v, mk("sys_drain1", 1, 1, 0, 0, 1, 1, 0, 16'd2));
    apply(v, mk("sys_drain2", 1, 1, 0, 0, 1, 1, 0, 16'd2));
    apply(v, mk("sys_issue", 0, 0, 0, 0, 1, 1, 1, 16'd2));
    apply(idle(), mk("sys_wait1", 1, 1, 0, 0, 1, 1, 0, 16'd2));
    v = idle(); v.redir = 1'b1;
    apply(v, mk("wait_ignores_redir", 1, 1, 0, 0, 1, 1, 0, 16'd2));
    v = idle(); v.done = 1'b1;
    apply(v, mk("wait_done", 0, 0, 0, 0, 1, 1, 0, 16'd2));
    apply(idle(), mk("back_to_run", 0, 0, 0, 0, 1, 1, 0, 16'd2));

    // redirect in second DRAIN cycle squashes the syscall
    v = idle(); v.sys = 1'b1;
    apply(v, mk("sq_run", 1, 1, 0, 0, 1, 1, 0, 16'd2));
    apply(v, mk("sq_drain1", 1, 1, 0, 0, 1, 1, 0, 16'd2));
    v.redir = 1'b1;
    apply(v, mk("sq_drain2_redir", 0, 1, 0, 0, 1, 1, 0, 16'd2));
    apply(idle(), mk("sq_run_a", 0, 0, 0, 0, 1, 1, 0, 16'd2));
    apply(idle(), mk("sq_run_b", 0, 0, 0, 0, 1, 1, 0, 16'd2));

    // drive the counter up to FFFE, then three more stalls saturate it
    cur = 16'd2;
    while (cur != 16'hFFFE) begin
      apply(ld5(), mk("count_ramp", 1, 1, 0, 0, 0, 1, 0, cur));
      cur = cur + 16'd1;
    end
    apply(ld5(), mk("sat_1", 1, 1, 0, 0, 0, 1, 0, 16'hFFFE));
    apply(ld5(), mk("sat_2", 1, 1, 0, 0, 0, 1, 0, 16'hFFFF));
    apply(ld5(), mk("sat_3", 1, 1, 0, 0, 0, 1, 0, 16'hFFFF));
    apply(idle(), mk("sat_hold", 0, 0, 0, 0, 1, 1, 0, 16'hFFFF));

    // reset mid-WAIT
    v = idle(); v.sys = 1'b1;
    apply(v, mk("r_sys_run", 1, 1, 0, 0, 1, 1, 0, 16'hFFFF));
    apply(v, mk("r_drain1", 1, 1, 0, 0, 1, 1, 0, 16'hFFFF));
    apply(v, mk("r_drain2", 1, 1, 0, 0, 1, 1, 0, 16'hFFFF));
    apply(v, mk("r_issue", 0, 0, 0, 0, 1, 1, 1, 16'hFFFF));
    apply(idle(), mk("r_wait", 1, 1, 0, 0, 1, 1, 0, 16'hFFFF));
    v = idle(); v.rst = 1'b1;
    apply(v, mk("rst_mid_wait", 0, 1, 0, 0, 0, 0, 0, 16'd0));
    apply(idle(), mk("post_rst_idle", 0, 0, 0, 0, 1, 1, 0, 16'd0));
    apply(ld5(), mk("post_rst_loaduse", 1, 1, 0, 0, 0, 1, 0, 16'd0));
    apply(idle(), mk("post_rst_count", 0, 0, 0, 0, 1, 1, 0, 16'd1));

    // fresh syscall; completion cycle behaves as RUN including a load-use stall
    v = idle(); v.sys = 1'b1;
    apply(v, mk("p_sys_run", 1, 1, 0, 0, 1, 1, 0, 16'd1));
    apply(v, mk("p_drain1", 1, 1, 0, 0, 1, 1, 0, 16'd1));
    apply(v, mk("p_drain2", 1, 1, 0, 0, 1, 1, 0, 16'd1));
    apply(v, mk("p_issue", 0, 0, 0, 0, 1, 1, 1, 16'd1));
    v = ld5(); v.done = 1'b1;
    apply(v, mk("p_done_loaduse", 1, 1, 0, 0, 0, 1, 0, 16'd1));
    apply(idle(), mk("p_run", 0, 0, 0, 0, 1, 1, 0, 16'd2));

    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (expq.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending, want 0", expq.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
